// File: rtl/instr_sequencer.sv
// Host-side instruction sequencer: queues 8-bit host instructions and presents
// them one at a time to the matrix unit control FSM, using fsm_busy as handshake.
module instr_sequencer #(
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [7:0]       cmd_instr,
  output logic             cmd_ready,
  input  logic             err_clear,
  input  logic             fsm_busy,
  output logic [7:0]       host_instruction,
  output logic             issue_pulse,
  output logic             done_pulse,
  output logic [CNT_W-1:0] fifo_count,
  output logic             seq_idle,
  output logic             timeout_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

  state_t           state;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [TMR_W-1:0] timer;
  logic [7:0]       head_entry;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             head_is_nop;
  logic             timer_expired;

  assign fifo_empty    = (fifo_count == '0);
  assign cmd_ready     = (fifo_count != CNT_W'(DEPTH));
  assign push          = cmd_valid && cmd_ready;
  assign head_entry    = mem[head_ptr];
  assign head_is_nop   = (head_entry[3:2] == 2'b00);
  assign timer_expired = (timer == TMR_W'(TIMEOUT - 1));
  assign seq_idle      = (state == IDLE) && fifo_empty;

  // The active instruction stays at the FIFO head until it completes or is abandoned.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !fifo_empty && head_is_nop;
      WAIT_HI: pop = !fsm_busy && timer_expired;
      WAIT_LO: pop = !fsm_busy;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[tail_ptr] <= cmd_instr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop)
        head_ptr <= head_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      timer            <= '0;
      host_instruction <= 8'h00;
      issue_pulse      <= 1'b0;
      done_pulse       <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      issue_pulse <= 1'b0;
      done_pulse  <= 1'b0;
      if (err_clear)
        timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          host_instruction <= 8'h00;
          if (!fifo_empty && !head_is_nop && !fsm_busy) begin
            host_instruction <= head_entry;
            issue_pulse      <= 1'b1;
            timer            <= '0;
            state            <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          timer <= timer + TMR_W'(1);
          if (fsm_busy) begin
            state <= WAIT_LO;
          end else if (timer_expired) begin
            // Setting takes priority over a simultaneous err_clear.
            timeout_err      <= 1'b1;
            host_instruction <= 8'h00;
            state            <= IDLE;
          end
        end
        WAIT_LO: begin
          if (!fsm_busy) begin
            host_instruction <= 8'h00;
            done_pulse       <= 1'b1;
            state            <= IDLE;
          end
        end
        default: begin
          host_instruction <= 8'h00;
          state            <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: fixed vector table, directed corner
// sequences and random traffic, all checked against a queue-based reference model.
module tb_instr_sequencer;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 16;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic [7:0]       cmd_instr;
  logic             cmd_ready;
  logic             err_clear;
  logic             fsm_busy;
  logic [7:0]       host_instruction;
  logic             issue_pulse;
  logic             done_pulse;
  logic [CNT_W-1:0] fifo_count;
  logic             seq_idle;
  logic             timeout_err;

  instr_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_instr(cmd_instr),
    .cmd_ready(cmd_ready),
    .err_clear(err_clear),
    .fsm_busy(fsm_busy),
    .host_instruction(host_instruction),
    .issue_pulse(issue_pulse),
    .done_pulse(done_pulse),
    .fifo_count(fifo_count),
    .seq_idle(seq_idle),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [7:0] instr;
    logic       busy;
    logic       clr;
    logic       rst;
    logic [7:0] exp_host;
    logic       exp_issue;
    logic       exp_done;
    int         exp_count;
    logic       exp_err;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: the queue holds every instruction not yet retired, the
  // active one included; m_wait counts cycles spent waiting for busy to rise.
  logic [7:0] mq[$];
  bit         m_active, m_seen;
  int         m_wait;
  logic [7:0] m_host;
  bit         m_issue, m_done, m_err;

  function automatic void modelStep(input logic v, input logic [7:0] ins,
                                    input logic b, input logic c, input logic r);
    bit accept, set_err;
    logic [7:0] head;
    if (r) begin
      mq.delete();
      m_active = 0; m_seen = 0; m_wait = 0;
      m_host = 8'h00; m_issue = 0; m_done = 0; m_err = 0;
      return;
    end
    accept  = v && (mq.size() < DEPTH);
    set_err = 0;
    m_issue = 0;
    m_done  = 0;
    if (!m_active) begin
      if (mq.size() > 0) begin
        head = mq[0];
        if (head[3:2] == 2'b00) begin
          void'(mq.pop_front());
        end else if (!b) begin
          m_active = 1; m_seen = 0; m_wait = 0;
          m_host = head; m_issue = 1;
        end
      end
    end else if (!m_seen) begin
      if (b) begin
        m_seen = 1;
      end else if (m_wait == TIMEOUT - 1) begin
        void'(mq.pop_front());
        m_active = 0; m_host = 8'h00; set_err = 1;
      end else begin
        m_wait++;
      end
    end else if (!b) begin
      void'(mq.pop_front());
      m_active = 0; m_host = 8'h00; m_done = 1;
    end
    if (set_err) m_err = 1;
    else if (c) m_err = 0;
    if (accept) mq.push_back(ins);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("host_instruction", host_instruction, m_host);
    checkVal("issue_pulse", issue_pulse, m_issue);
    checkVal("done_pulse", done_pulse, m_done);
    checkVal("fifo_count", fifo_count, mq.size());
    checkVal("cmd_ready", cmd_ready, mq.size() < DEPTH);
    checkVal("seq_idle", seq_idle, !m_active && mq.size() == 0);
    checkVal("timeout_err", timeout_err, m_err);
  endtask

  // Inputs change at the falling edge; outputs are compared at the next falling edge.
  task automatic applyStimulus(input logic v, input logic [7:0] ins,
                               input logic b, input logic c, input logic r);
    cmd_valid = v; cmd_instr = ins; fsm_busy = b; err_clear = c; reset = r;
    @(posedge clk);
    modelStep(v, ins, b, c, r);
    @(negedge clk);
    checkOutput();
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] ins, input logic b,
                              input logic c, input logic r, input logic [7:0] eh,
                              input logic ei, input logic ed, input int ec, input logic ee);
    vec_t t;
    t.valid = v; t.instr = ins; t.busy = b; t.clr = c; t.rst = r;
    t.exp_host = eh; t.exp_issue = ei; t.exp_done = ed; t.exp_count = ec; t.exp_err = ee;
    return t;
  endfunction

  vec_t       tbl[$];
  logic [7:0] pushed[$];
  logic [7:0] issued[$];

  task automatic fillAndDrain(input int base);
    logic [7:0] ins;
    int b;
    pushed.delete();
    issued.delete();
    for (int i = 0; i < DEPTH; i++) begin
      ins = 8'(((base + i) % 16) * 16 + 5);
      pushed.push_back(ins);
      applyStimulus(1, ins, 1, 0, 0);
    end
    checkVal("full_count", fifo_count, DEPTH);
    checkVal("full_ready", cmd_ready, 0);
    applyStimulus(1, 8'hEE, 1, 0, 0);
    checkVal("ninth_rejected", fifo_count, DEPTH);
    for (int cyc = 0; cyc < 100; cyc++) begin
      b = (cyc / 2) % 2;
      applyStimulus(0, 8'h00, b[0], 0, 0);
      if (issue_pulse) issued.push_back(host_instruction);
    end
    checkVal("order_size", issued.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++)
      checkVal($sformatf("order%0d", i), (i < issued.size()) ? issued[i] : 8'hxx, pushed[i]);
  endtask

  task automatic runTimeout(input logic clr_during, input logic exp_err);
    int dones = 0;
    applyStimulus(1, 8'h07, 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0);
    checkVal("to_issue", issue_pulse, 1);
    for (int k = 0; k < TIMEOUT; k++) begin
      applyStimulus(0, 8'h00, 0, clr_during, 0);
      if (done_pulse) dones++;
      if (k < TIMEOUT - 1) checkVal("to_hold", host_instruction, 8'h07);
    end
    checkVal("to_err", timeout_err, exp_err);
    checkVal("to_host", host_instruction, 8'h00);
    checkVal("to_count", fifo_count, 0);
    checkVal("to_no_done", dones, 0);
  endtask

  initial begin
    int dones;
    logic busy_r;
    cmd_valid = 0; cmd_instr = 0; fsm_busy = 0; err_clear = 0; reset = 1;
    @(negedge clk);

    // Basic issue, then NOP discard (F3 and 00 dropped, 05 issued).
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h4C, 0, 0, 0, 8'h00, 0, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'h4C, 1, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'h4C, 0, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h4C, 0, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h4C, 0, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'hF3, 0, 0, 0, 8'h00, 0, 0, 1, 0));
    tbl.push_back(mk(1, 8'h05, 0, 0, 0, 8'h00, 0, 0, 1, 0));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 8'h05, 1, 0, 2, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h05, 0, 0, 2, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].valid, tbl[i].instr, tbl[i].busy, tbl[i].clr, tbl[i].rst);
      checkVal($sformatf("tbl%0d_host", i), host_instruction, tbl[i].exp_host);
      checkVal($sformatf("tbl%0d_issue", i), issue_pulse, tbl[i].exp_issue);
      checkVal($sformatf("tbl%0d_done", i), done_pulse, tbl[i].exp_done);
      checkVal($sformatf("tbl%0d_count", i), fifo_count, tbl[i].exp_count);
      checkVal($sformatf("tbl%0d_err", i), timeout_err, tbl[i].exp_err);
    end

    // Full FIFO, ordering, and a second fill to exercise pointer wrap.
    applyStimulus(0, 8'h00, 0, 0, 1);
    fillAndDrain(0);
    fillAndDrain(8);

    // Timeout, clear, and set-beats-clear on the same edge.
    applyStimulus(0, 8'h00, 0, 0, 1);
    runTimeout(0, 1);
    applyStimulus(0, 8'h00, 0, 1, 0);
    checkVal("err_cleared", timeout_err, 0);
    runTimeout(1, 1);
    applyStimulus(0, 8'h00, 0, 1, 0);
    checkVal("err_cleared2", timeout_err, 0);

    // Reset with one instruction in WAIT_LO and three queued behind it.
    applyStimulus(1, 8'h15, 0, 0, 0);
    applyStimulus(1, 8'h25, 0, 0, 0);
    applyStimulus(1, 8'h35, 1, 0, 0);
    applyStimulus(1, 8'h45, 1, 0, 0);
    checkVal("pre_rst_count", fifo_count, 4);
    applyStimulus(0, 8'h00, 1, 0, 1);
    checkVal("rst_host", host_instruction, 8'h00);
    checkVal("rst_issue", issue_pulse, 0);
    checkVal("rst_count", fifo_count, 0);
    checkVal("rst_idle", seq_idle, 1);
    checkVal("rst_ready", cmd_ready, 1);
    applyStimulus(1, 8'h4C, 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0);
    checkVal("post_rst_issue", issue_pulse, 1);
    checkVal("post_rst_host", host_instruction, 8'h4C);
    applyStimulus(0, 8'h00, 1, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0);
    checkVal("post_rst_done", done_pulse, 1);

    // Long LOAD must not time out while busy stays high.
    dones = 0;
    applyStimulus(1, 8'h84, 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0);
    for (int k = 0; k < 70; k++) begin
      applyStimulus(0, 8'h00, 1, 0, 0);
      checkVal("long_host", host_instruction, 8'h84);
      if (done_pulse) dones++;
    end
    checkVal("long_no_err", timeout_err, 0);
    applyStimulus(0, 8'h00, 0, 0, 0);
    if (done_pulse) dones++;
    applyStimulus(0, 8'h00, 0, 0, 0);
    if (done_pulse) dones++;
    checkVal("long_done_once", dones, 1);

    // Random traffic; busy moves in runs so both timeouts and long ops occur.
    busy_r = 0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 7) == 0) busy_r = ~busy_r;
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), busy_r,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected $finish before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
